// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the CPU data-memory responder.
// Contents: default geometry constants, request/response structs, byte-enable
// type, the responder state enum and the address fault helper.
package data_mem_responder_pkg;

    localparam int          DefDataWidth    = 32;
    localparam int          DefDataCapacity = 128;
    localparam logic [31:0] DefDataOffset   = 32'h1001_0000;
    localparam int          DefWaitStates   = 2;

    typedef logic [DefDataWidth/8-1:0] ByteEnable;

    typedef struct packed {
        logic                    write;
        logic [31:0]             addr;
        ByteEnable               be;
        logic [DefDataWidth-1:0] wdata;
    } DataMemReq;

    typedef struct packed {
        logic                    err;
        logic [DefDataWidth-1:0] rdata;
    } DataMemResp;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Wait = 2'd1,
        Resp = 2'd2
    } DataMemState;

    // A request faults when it lies below the window, at or beyond its end,
    // or is not word aligned. off is addr - base (wraps when addr < base,
    // which the first term catches).
    function automatic logic addrFault(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] off,
                                       input logic [31:0] limit);
        return (addr < base) || (off >= limit) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU memory stage and the data responder.
// master: CPU side (drives request and resp_ready).
// slave : responder side (drives req_ready and the response).
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int DataWidth = DefDataWidth
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [31:0]            req_addr;
    logic [DataWidth/8-1:0] req_be;
    logic [DataWidth-1:0]   req_wdata;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DataWidth-1:0]   resp_rdata;
    logic                   resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_array.sv
// Word storage for the data responder: DataCapacity x DataWidth, synchronous
// byte-lane write and registered read. Contents are intentionally not reset.
// Ports: clk, we (write strobe), re (read strobe), index (word index),
//        be (lane enables), wdata, rdata (registered read data).
module data_mem_array #(
    parameter int DataWidth     = 32,
    parameter int DataCapacity  = 128,
    parameter int DataAddrWidth = 7
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [DataAddrWidth-1:0] index,
    input  logic [DataWidth/8-1:0]   be,
    input  logic [DataWidth-1:0]     wdata,
    output logic [DataWidth-1:0]     rdata
);

    logic [DataWidth-1:0] mem_r [DataCapacity];
    logic [DataWidth-1:0] rdata_r;

    // Byte-lane write: only enabled lanes change; be == 0 leaves the word intact.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DataWidth/8; i++) begin
                if (be[i]) begin
                    mem_r[index][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read; value holds until the next read strobe.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[index];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port. Accepts one load/store at a
// time, waits WaitStates cycles, then checks the address, accesses storage
// and presents the response until the CPU takes it.
// Ports: clk, rst_n (async active-low), bus (slave side of the request/response
//        bundle), err_addr (last faulting address), err_count (saturating faults).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DataWidth    = DefDataWidth,
    parameter int          DataCapacity = DefDataCapacity,
    parameter logic [31:0] DataOffset   = DefDataOffset,
    parameter int          WaitStates   = DefWaitStates
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus,
    output logic [31:0]          err_addr,
    output logic [7:0]           err_count
);

    localparam int          DataAddrWidth = $clog2(DataCapacity);
    localparam logic [31:0] DataLimit     = 32'(DataCapacity * 4);
    localparam logic [3:0]  WaitLoad      = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;
    localparam logic        ZeroWait      = (WaitStates == 0);

    DataMemState              state_r, next_state_s;
    logic [3:0]               wait_cnt_r;
    DataMemReq                req_r, req_in_s, req_eff_s;
    DataMemResp               resp_s;
    logic                     xfer_s, enter_resp_s, fault_s;
    logic [31:0]              off_s;
    logic [DataAddrWidth-1:0] index_s;
    logic                     arr_we_s, arr_re_s;
    logic [DataWidth-1:0]     arr_rdata_s;
    logic                     resp_err_r, load_ok_r;
    logic [31:0]              err_addr_r;
    logic [7:0]               err_count_r;

    // Next-state logic: transfer only in Idle, response held until resp_ready.
    always_comb begin
        next_state_s = state_r;
        xfer_s       = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            Idle: begin
                if (bus.req_valid) begin
                    xfer_s = 1'b1;
                    if (ZeroWait) begin
                        next_state_s = Resp;
                        enter_resp_s = 1'b1;
                    end else begin
                        next_state_s = Wait;
                    end
                end else begin
                    next_state_s = Idle;
                end
            end
            Wait: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = Resp;
                    enter_resp_s = 1'b1;
                end else begin
                    next_state_s = Wait;
                end
            end
            Resp: begin
                if (bus.resp_ready) begin
                    next_state_s = Idle;
                end else begin
                    next_state_s = Resp;
                end
            end
            default: next_state_s = Idle;
        endcase
    end

    // Translation and fault check; with zero wait states the access happens on
    // the transfer edge itself, so the live bus request is used instead of the latch.
    always_comb begin
        req_in_s  = '{write: bus.req_write, addr: bus.req_addr,
                      be: bus.req_be, wdata: bus.req_wdata};
        req_eff_s = (state_r == Idle) ? req_in_s : req_r;
        off_s     = req_eff_s.addr - DataOffset;
        index_s   = off_s[DataAddrWidth+1:2];
        fault_s   = addrFault(req_eff_s.addr, DataOffset, off_s, DataLimit);
        arr_we_s  = enter_resp_s && !fault_s && req_eff_s.write;
        arr_re_s  = enter_resp_s && !fault_s && !req_eff_s.write;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= Idle;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait-state counter and request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
            req_r      <= '0;
        end else if (xfer_s) begin
            wait_cnt_r <= WaitLoad;
            req_r      <= req_in_s;
        end else if ((state_r == Wait) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Response flags: set on RESP entry, cleared once the CPU takes the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_r <= 1'b0;
            load_ok_r  <= 1'b0;
        end else if (enter_resp_s) begin
            resp_err_r <= fault_s;
            load_ok_r  <= !fault_s && !req_eff_s.write;
        end else if ((state_r == Resp) && bus.resp_ready) begin
            resp_err_r <= 1'b0;
            load_ok_r  <= 1'b0;
        end
    end

    // Fault bookkeeping for the exception path; count saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_r  <= 32'd0;
            err_count_r <= 8'd0;
        end else if (enter_resp_s && fault_s) begin
            err_addr_r <= req_eff_s.addr;
            if (err_count_r != 8'hFF) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    data_mem_array #(
        .DataWidth     (DataWidth),
        .DataCapacity  (DataCapacity),
        .DataAddrWidth (DataAddrWidth)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .index (index_s),
        .be    (req_eff_s.be),
        .wdata (req_eff_s.wdata),
        .rdata (arr_rdata_s)
    );

    // Read data only reaches the bus for successful loads; stores and faults read 0.
    assign resp_s.err   = resp_err_r;
    assign resp_s.rdata = load_ok_r ? arr_rdata_s : {DataWidth{1'b0}};

    assign bus.req_ready  = (state_r == Idle);
    assign bus.resp_valid = (state_r == Resp);
    assign bus.resp_err   = resp_s.err;
    assign bus.resp_rdata = resp_s.rdata;
    assign err_addr       = err_addr_r;
    assign err_count      = err_count_r;

endmodule
